mem_stream_reader: RTL and testbench
====================================

Name: mem_stream_reader

Overview:
- Avalon-MM read master that sits directly upstream of the single-port on-chip RAM slave (14-bit word address, 32-bit data, fixed 1-cycle read latency).
- Reads a CPU-programmed block of words and emits them as an Avalon-ST packet with valid/ready backpressure.
- Includes a small output FIFO, so RAM reads are issued only when buffer space is guaranteed.
- Has a 4-register control slave for the Nios CPU.

Parameters:
- ADDR_W, 14, RAM word-address width.
- DATA_W, 32, RAM and stream data width.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_address  in  2  control register select.
- ctrl_write  in  1  control write strobe.
- ctrl_writedata  in  32  control write data.
- ctrl_read  in  1  control read strobe (zero wait states).
- ctrl_readdata  out  32  register read data; combinational from ctrl_address.
- mem_address  out  ADDR_W  RAM word address.
- mem_chipselect  out  1  RAM access strobe.
- mem_write  out  1  constant 0.
- mem_byteenable  out  4  constant 4'hF.
- mem_clken  out  1  constant 1.
- mem_readdata  in  DATA_W  RAM data; valid exactly 1 cycle after a read issue.
- src_data  out  DATA_W  stream data (FIFO head).
- src_valid  out  1  stream valid.
- src_ready  in  1  stream ready; readyLatency 0.
- src_startofpacket  out  1  first word of a block.
- src_endofpacket  out  1  last word of a block.

Behaviour:
- All flops use synchronous reset. After reset:
  - regs, counters, FIFO cleared; state IDLE.
  - mem_chipselect=0, mem_address=0, src_valid=0, SOP=0, EOP=0.
- Registers:
  - 0 START (rw, ADDR_W bits).
  - 1 LENGTH (rw, ADDR_W+1 bits, 0..2^ADDR_W).
  - 2 CONTROL (wo):
    - bit0 GO: one-cycle pulse.
    - bit1 ABORT: one-cycle pulse.
    - Reads of CONTROL return 0.
  - 3 STATUS:
    - bit0 BUSY (ro).
    - bit1 DONE (sticky, write-1-clear).
    - bit2 ABORTED (sticky, write-1-clear).
    - bits[31:16] words_sent so far.
- START/LENGTH writes while BUSY are ignored.
- FSM states:
  - IDLE:
    - GO with LENGTH=0: DONE<=1, stay IDLE, no RAM access.
    - GO with LENGTH>0: load addr<=START, remaining<=LENGTH, sent<=0, go to RUN, clear DONE and ABORTED.
  - RUN:
    - Issue a read (mem_chipselect=1, mem_address=addr) in a cycle when remaining>0 and fifo_count+inflight < FIFO_DEPTH.
    - On issue: addr<=addr+1 (wraps mod 2^ADDR_W, 16383 to 0); remaining<=remaining-1.
    - inflight is 1 for the cycle after an issue; mem_readdata is pushed into the FIFO in that cycle.
    - When remaining=0, go to DRAIN.
  - DRAIN: wait until inflight=0 and FIFO empty, then DONE<=1 and go to IDLE.
  - BUSY = (state != IDLE).
- Stream handshake:
  - Pop on src_valid & src_ready; sent increments on each pop.
  - SOP=1 on the word with sent=0; EOP=1 on the word with sent=LENGTH-1.
  - A single-word block has SOP=EOP=1.
  - src_valid never deasserts without a pop; src_data is stable while valid & !ready.
- Simultaneous push and pop in one cycle: count unchanged, both take effect.
  - Full-throughput steady state is 1 word/cycle when src_ready is held 1.
- GO while BUSY: ignored.
- GO and ABORT in the same cycle: ABORT wins (nothing starts if IDLE).
- ABORT while RUN or DRAIN:
  - Stop issuing immediately.
  - Any in-flight word is discarded; FIFO flushed on the cycle inflight=0.
  - ABORTED<=1, DONE unchanged, go to IDLE.
  - No EOP emitted; src_valid drops on the flush cycle.
- ABORT while IDLE: ignored.
- Reset mid-operation: everything returns to reset values on the next edge; in-flight read data is dropped.

Decomposition:
- Shared package mem_stream_pkg:
  - register offsets (REG_START=0, REG_LENGTH=1, REG_CONTROL=2, REG_STATUS=3).
  - CONTROL/STATUS bit indices.
  - FSM state encoding (IDLE, RUN, DRAIN).
- One sub-module, sync_fifo:
  - Parameterised by width and depth.
  - Ports: push, pop, flush, data in, head out, count, full, empty.
  - Synchronous reset.
  - Data width DATA_W+2 so SOP/EOP are tagged at push time.

Test Plan:
- START=0x0010, LENGTH=4, GO, src_ready=1 → reads at 0x10..0x13 on 4 consecutive cycles; 4 stream words equal RAM[0x10..0x13]; SOP on word 0, EOP on word 3; DONE=1; words_sent=4.
- LENGTH=0, GO → no mem_chipselect; DONE=1 next cycle; BUSY never 1.
- START=0x3FFE, LENGTH=4 → addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001; data order preserved.
- LENGTH=16, src_ready toggled randomly/held 0 for 20 cycles → issued-but-unpopped words never exceed 4; no loss or duplication; all 16 words in order; src_data stable while stalled.
- LENGTH=100, ABORT after 10 pops → chipselect stops the same cycle; src_valid low within 2 cycles; ABORTED=1, DONE=0, BUSY=0; a new GO then works normally.
- Assert reset mid-block with FIFO full → next cycle all outputs at reset values and STATUS=0; GO with LENGTH=1 afterwards → single word with SOP=EOP=1.

Source files
------------

// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the RAM-to-stream block reader: register map,
// control/status bit positions and the sequencer state encoding.
package mem_stream_pkg;

  localparam logic [1:0] REG_START   = 2'd0;
  localparam logic [1:0] REG_LENGTH  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_GO       = 0;
  localparam int CTRL_ABORT    = 1;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_ABORTED  = 2;
  localparam int STAT_SENT_LSB = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Bundles the CPU control slave, the RAM read-master and the Avalon-ST source.
// master = the reader itself, slave = the surrounding system.
interface mem_stream_reader_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [1:0]        ctrl_address;
  logic              ctrl_write;
  logic [31:0]       ctrl_writedata;
  logic              ctrl_read;
  logic [31:0]       ctrl_readdata;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_startofpacket;
  logic              src_endofpacket;

  modport master (
    input  ctrl_address, ctrl_write, ctrl_writedata, ctrl_read,
    output ctrl_readdata,
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  mem_readdata,
    output src_data, src_valid, src_startofpacket, src_endofpacket,
    input  src_ready
  );

  modport slave (
    output ctrl_address, ctrl_write, ctrl_writedata, ctrl_read,
    input  ctrl_readdata,
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input  src_data, src_valid, src_startofpacket, src_endofpacket,
    output src_ready
  );
endinterface

// File: rtl/mem_stream_reader_sync_fifo.sv
// Small synchronous FIFO with a combinational head; flush empties it in one
// cycle. Storage is not reset, only pointers and occupancy are.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mem_stream_reader.sv
// Reads a CPU-programmed block of RAM words and streams them out as one
// Avalon-ST packet; reads are only issued when FIFO space is guaranteed.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_stream_reader_if.master bus
);
  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TAG_W = DATA_W + 2;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(2 ** ADDR_W);

  function automatic logic [LEN_W-1:0] sat_length(input logic [31:0] v);
    if (v > 32'(LEN_MAX)) return LEN_MAX;
    return v[LEN_W-1:0];
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] start_reg;
  logic [LEN_W-1:0]  length_reg;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  sent;
  logic              done;
  logic              aborted;

  logic              busy;
  logic              wr_control;
  logic              go_req;
  logic              abort_req;
  logic              abort_hit;
  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              sop_p0;
  logic              eop_p0;

  logic              vld_p1;
  logic              sop_p1;
  logic              eop_p1;

  logic              push;
  logic              pop;
  logic [TAG_W-1:0]  fifo_din;
  logic [TAG_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign unused_bits = ^{bus.ctrl_read, bus.ctrl_writedata, fifo_full};

  assign busy       = (state != IDLE);
  assign wr_control = bus.ctrl_write && (bus.ctrl_address == REG_CONTROL);
  assign abort_req  = wr_control && bus.ctrl_writedata[CTRL_ABORT];
  // ABORT beats GO in the same write, even when there is nothing to abort.
  assign go_req     = wr_control && bus.ctrl_writedata[CTRL_GO] && !abort_req;
  assign abort_hit  = abort_req && busy;

  // Stage p0: issue decision; in-flight word counts against FIFO space.
  assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(vld_p1);
  assign issue     = (state == RUN) && (remaining != '0) &&
                     (occupancy < (CNT_W+1)'(FIFO_DEPTH)) && !abort_req;
  assign sop_p0    = (remaining == length_reg);
  assign eop_p0    = (remaining == LEN_W'(1));

  assign bus.mem_address    = addr;
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;

  // Stage p1: RAM data returns and is pushed with its packet tags.
  assign push     = vld_p1 && !abort_hit;
  assign fifo_din = {sop_p1, eop_p1, bus.mem_readdata};
  assign pop      = !fifo_empty && bus.src_ready;

  sync_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (abort_hit),
    .din   (fifo_din),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.src_valid         = !fifo_empty;
  assign bus.src_data          = fifo_head[DATA_W-1:0];
  assign bus.src_startofpacket = fifo_head[DATA_W+1] && !fifo_empty;
  assign bus.src_endofpacket   = fifo_head[DATA_W]   && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      start_reg  <= '0;
      length_reg <= '0;
      addr       <= '0;
      remaining  <= '0;
      sent       <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      vld_p1     <= 1'b0;
      sop_p1     <= 1'b0;
      eop_p1     <= 1'b0;
    end else begin
      vld_p1 <= issue;
      sop_p1 <= sop_p0;
      eop_p1 <= eop_p0;

      if (pop) sent <= sent + LEN_W'(1);

      if (bus.ctrl_write && !busy) begin
        if (bus.ctrl_address == REG_START)  start_reg  <= bus.ctrl_writedata[ADDR_W-1:0];
        if (bus.ctrl_address == REG_LENGTH) length_reg <= sat_length(bus.ctrl_writedata);
      end
      if (bus.ctrl_write && (bus.ctrl_address == REG_STATUS)) begin
        if (bus.ctrl_writedata[STAT_DONE])    done    <= 1'b0;
        if (bus.ctrl_writedata[STAT_ABORTED]) aborted <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (go_req) begin
            if (length_reg == '0) begin
              done <= 1'b1;
            end else begin
              addr      <= start_reg;
              remaining <= length_reg;
              sent      <= '0;
              done      <= 1'b0;
              aborted   <= 1'b0;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (abort_hit) begin
            aborted <= 1'b1;
            state   <= IDLE;
          end else begin
            if (issue) begin
              addr      <= addr + ADDR_W'(1);
              remaining <= remaining - LEN_W'(1);
            end
            if (remaining == '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort_hit) begin
            aborted <= 1'b1;
            state   <= IDLE;
          end else if (!vld_p1 && fifo_empty) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.ctrl_address)
      REG_START:  rdata = 32'(start_reg);
      REG_LENGTH: rdata = 32'(length_reg);
      REG_STATUS: begin
        rdata[STAT_BUSY]    = busy;
        rdata[STAT_DONE]    = done;
        rdata[STAT_ABORTED] = aborted;
        rdata[31:STAT_SENT_LSB] = 16'(sent);
      end
      default:    rdata = '0;
    endcase
  end
  assign bus.ctrl_readdata = rdata;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized bench for mem_stream_reader: RAM model, stream scoreboard and a
// block-level reference (address = start+i mod 2^14, SOP/EOP by word index).
module tb_mem_stream_reader;
  import mem_stream_pkg::*;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int NWORD = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [DW-1:0] ram [NWORD];
  always @(posedge clk)
    bus.mem_readdata <= bus.mem_chipselect ? ram[bus.mem_address] : $urandom;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [AW-1:0]   addr_q [$];
  int              cyc_q  [$];
  logic [DW+1:0]   got_q  [$];
  int              cyc = 0;
  int              max_out = 0;
  bit              skip_stall = 0;
  bit              stall_prev = 0;
  logic [DW-1:0]   prev_data;
  logic            cs_at_abort;
  int              rdy_mode = 0;

  // Monitor: samples mid-cycle what the next rising edge will commit.
  always @(negedge clk) begin
    int out;
    cyc++;
    if (!reset) begin
      if (bus.mem_chipselect) begin
        addr_q.push_back(bus.mem_address);
        cyc_q.push_back(cyc);
      end
      out = addr_q.size() - got_q.size();
      if (out > max_out) max_out = out;
      if (stall_prev && !skip_stall) begin
        check_eq("stall_valid", 64'(bus.src_valid), 64'd1);
        check_eq("stall_data", 64'(bus.src_data), 64'(prev_data));
      end
      if (bus.src_valid && bus.src_ready)
        got_q.push_back({bus.src_startofpacket, bus.src_endofpacket, bus.src_data});
      stall_prev = bus.src_valid && !bus.src_ready;
      prev_data  = bus.src_data;
      if (bus.ctrl_write && bus.ctrl_address == REG_CONTROL && bus.ctrl_writedata[CTRL_ABORT])
        cs_at_abort = bus.mem_chipselect;
    end else begin
      stall_prev = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus.src_ready = 1'b1;
      1:       bus.src_ready = 1'($urandom_range(0, 1));
      2:       bus.src_ready = 1'b0;
      default: bus.src_ready = (got_q.size() < 10);
    endcase
  end

  task automatic ctrl_wr(input logic [1:0] a, input logic [31:0] d);
    bus.ctrl_address   = a;
    bus.ctrl_writedata = d;
    bus.ctrl_write     = 1'b1;
    @(posedge clk);
    #1;
    bus.ctrl_write     = 1'b0;
  endtask

  task automatic ctrl_rd(input logic [1:0] a, output logic [31:0] d);
    bus.ctrl_address = a;
    bus.ctrl_read    = 1'b1;
    #1;
    d = bus.ctrl_readdata;
    bus.ctrl_read    = 1'b0;
  endtask

  task automatic start_block(input int start, input int len);
    ctrl_wr(REG_START, 32'(start));
    ctrl_wr(REG_LENGTH, 32'(len));
    addr_q.delete();
    cyc_q.delete();
    got_q.delete();
    max_out = 0;
    ctrl_wr(REG_CONTROL, 32'h1);
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] s;
    int n = 0;
    ctrl_rd(REG_STATUS, s);
    while (s[STAT_BUSY] && n < budget) begin
      @(posedge clk);
      #1;
      ctrl_rd(REG_STATUS, s);
      n++;
    end
    check_eq("idle_timeout", 64'(s[STAT_BUSY]), 64'd0);
  endtask

  task automatic check_block(input string tag, input int start, input int len, input int nwords);
    logic [DW+1:0] exp;
    int a;
    check_eq({tag, "_nwords"}, 64'(got_q.size()), 64'(nwords));
    for (int i = 0; i < nwords && i < got_q.size(); i++) begin
      a   = (start + i) % NWORD;
      exp = {i == 0, i == len - 1, ram[a]};
      check_eq({tag, "_word"}, 64'(got_q[i]), 64'(exp));
    end
    for (int i = 0; i < nwords && i < addr_q.size(); i++)
      check_eq({tag, "_addr"}, 64'(addr_q[i]), 64'((start + i) % NWORD));
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] s;
    ctrl_rd(REG_STATUS, s);
    check_eq(tag, 64'(s), 64'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cs"},    64'(bus.mem_chipselect),      64'd0);
    check_eq({tag, "_addr"},  64'(bus.mem_address),         64'd0);
    check_eq({tag, "_valid"}, 64'(bus.src_valid),           64'd0);
    check_eq({tag, "_sop"},   64'(bus.src_startofpacket),   64'd0);
    check_eq({tag, "_eop"},   64'(bus.src_endofpacket),     64'd0);
    check_eq({tag, "_const"}, 64'({bus.mem_write, bus.mem_byteenable, bus.mem_clken}), 64'b0_1111_1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] s;
    int st, ln, n_iss;
    for (int i = 0; i < NWORD; i++) ram[i] = $urandom;
    reset = 1'b1;
    bus.ctrl_address = '0;
    bus.ctrl_write = 1'b0;
    bus.ctrl_writedata = '0;
    bus.ctrl_read = 1'b0;
    bus.src_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    check_status("rst_status", 32'h0);
    ctrl_rd(REG_START, s);  check_eq("rst_start", 64'(s), 64'd0);
    ctrl_rd(REG_LENGTH, s); check_eq("rst_length", 64'(s), 64'd0);

    // Basic block, full throughput.
    rdy_mode = 0;
    start_block(32'h10, 4);
    wait_idle(100);
    check_block("blk4", 32'h10, 4, 4);
    check_eq("blk4_ncyc", 64'(cyc_q.size()), 64'd4);
    if (cyc_q.size() == 4) check_eq("blk4_back2back", 64'(cyc_q[3] - cyc_q[0]), 64'd3);
    check_status("blk4_status", (32'd4 << 16) | 32'h2);
    ctrl_rd(REG_START, s);  check_eq("rb_start", 64'(s), 64'h10);
    ctrl_rd(REG_LENGTH, s); check_eq("rb_length", 64'(s), 64'd4);

    // LENGTH=0: immediate DONE, no RAM traffic.
    ctrl_wr(REG_STATUS, 32'h6);
    check_status("w1c_status", 32'd4 << 16);
    start_block(32'h20, 0);
    check_status("len0_status", (32'd4 << 16) | 32'h2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      ctrl_rd(REG_STATUS, s);
      check_eq("len0_busy", 64'(s[STAT_BUSY]), 64'd0);
    end
    check_eq("len0_no_reads", 64'(addr_q.size()), 64'd0);

    // Address wrap at the top of RAM, random backpressure.
    rdy_mode = 1;
    start_block(32'h3FFE, 4);
    wait_idle(200);
    check_block("wrap", 32'h3FFE, 4, 4);
    check_status("wrap_status", (32'd4 << 16) | 32'h2);

    // Long stall then random ready.
    rdy_mode = 2;
    st = $urandom_range(0, NWORD - 1);
    start_block(st, 16);
    repeat (20) @(posedge clk);
    #1;
    check_eq("stall_issued", 64'(addr_q.size()), 64'd4);
    check_eq("stall_popped", 64'(got_q.size()), 64'd0);
    rdy_mode = 1;
    wait_idle(500);
    check_block("stall16", st, 16, 16);
    check_eq("stall16_outstanding_le4", 64'(max_out > 4), 64'd0);
    check_status("stall16_status", (32'd16 << 16) | 32'h2);

    // Random blocks.
    for (int k = 0; k < 4; k++) begin
      rdy_mode = (k == 0) ? 0 : 1;
      st = $urandom_range(0, NWORD - 1);
      ln = $urandom_range(1, 40);
      start_block(st, ln);
      wait_idle(1000);
      check_block("rand", st, ln, ln);
      check_eq("rand_outstanding_le4", 64'(max_out > 4), 64'd0);
      check_status("rand_status", (32'(ln) << 16) | 32'h2);
    end

    // ABORT after 10 pops.
    skip_stall = 1;
    rdy_mode = 3;
    st = $urandom_range(0, NWORD - 1);
    start_block(st, 100);
    for (int i = 0; i < 300 && got_q.size() < 10; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("abort_reached10", 64'(got_q.size()), 64'd10);
    cs_at_abort = 1'bx;
    ctrl_wr(REG_CONTROL, 32'h2);
    check_eq("abort_cs_same_cycle", 64'(cs_at_abort), 64'd0);
    n_iss = addr_q.size();
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_valid_low", 64'(bus.src_valid), 64'd0);
    check_eq("abort_eop_low", 64'(bus.src_endofpacket), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_no_more_reads", 64'(addr_q.size()), 64'(n_iss));
    check_block("abort", st, 100, 10);
    check_status("abort_status", (32'd10 << 16) | 32'h4);
    rdy_mode = 0;
    skip_stall = 0;
    @(posedge clk);
    #1;
    st = $urandom_range(0, NWORD - 1);
    start_block(st, 5);
    wait_idle(200);
    check_block("post_abort", st, 5, 5);
    check_status("post_abort_status", (32'd5 << 16) | 32'h2);

    // GO+ABORT in IDLE: nothing starts.
    start_block(st, 3);
    wait_idle(200);
    addr_q.delete();
    ctrl_wr(REG_CONTROL, 32'h3);
    repeat (3) @(posedge clk);
    #1;
    check_eq("goabort_no_reads", 64'(addr_q.size()), 64'd0);
    check_status("goabort_status", (32'd3 << 16) | 32'h2);

    // Reset in the middle of a block with the FIFO full.
    skip_stall = 1;
    rdy_mode = 2;
    start_block($urandom_range(0, NWORD - 1), 50);
    repeat (10) @(posedge clk);
    #1;
    check_eq("prerst_full", 64'(addr_q.size()), 64'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_status("midrst_status", 32'h0);
    ctrl_rd(REG_START, s);
    check_eq("midrst_start", 64'(s), 64'd0);
    skip_stall = 0;
    rdy_mode = 0;
    st = $urandom_range(0, NWORD - 1);
    start_block(st, 1);
    wait_idle(100);
    check_block("single", st, 1, 1);
    check_status("single_status", (32'd1 << 16) | 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
